uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and byte sequencer that shares one uart_tx instance between NREQ requesters.
- Each requester presents a message of up to NBYTES bytes with a length. The block grants one requester, latches its message, and issues the bytes to uart_tx one at a time, MSB byte first.
- It sits between the datapath result/status producers and uart_tx. It replaces per-producer send FSMs.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart_tx arbiter slice
//
// Contents:
//   state_e      sequencer state encoding (IDLE, SEND, WAIT, DONE)
//   CLK_FREQ     default system clock frequency in Hz
//   BAUD_RATE    default serial line rate
//   len_width()  width of a length field able to hold 0..nbytes
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int CLK_FREQ  = 125_000_000;
  localparam int BAUD_RATE = 115_200;

  // One extra bit so that a full-length message (== nbytes) is representable.
  function automatic int len_width(input int nbytes);
    return $clog2(nbytes) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin request selector
//
// Ports:
//   iReq  [NREQ-1:0]   request vector
//   iPtr  [PTR_W-1:0]  index holding highest priority this round (< NREQ)
//   oGnt  [NREQ-1:0]   one-hot grant, all zero when no request
//   oIdx  [PTR_W-1:0]  index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  iReq,
  input  logic [PTR_W-1:0] iPtr,
  output logic [NREQ-1:0]  oGnt,
  output logic [PTR_W-1:0] oIdx
);

  // One extra bit: iPtr + i reaches at most 2*NREQ-2 before wrapping.
  logic [PTR_W:0] cand;
  logic           found;

  always_comb begin
    oGnt  = '0;
    oIdx  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, iPtr} + (PTR_W + 1)'(i);
      if (cand >= (PTR_W + 1)'(NREQ)) begin
        cand = cand - (PTR_W + 1)'(NREQ);
      end
      if (!found && iReq[cand[PTR_W-1:0]]) begin
        found                  = 1'b1;
        oGnt[cand[PTR_W-1:0]]  = 1'b1;
        oIdx                   = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter and byte sequencer sharing one uart_tx
//
// Ports:
//   iClk, iRst   clock, asynchronous active-high reset
//   iReq         per-requester level request, held until its oDone bit pulses
//   iData        NREQ messages of NBYTES bytes; requester k at [k*NBYTES*8 +: NBYTES*8]
//   iLen         NREQ byte counts; requester k at [k*LEN_W +: LEN_W]
//   oGnt         one-hot grant held for the whole message (through the DONE cycle)
//   oDone        one-cycle pulse on the granted bit when the message completes
//   oBusy        high whenever the sequencer is not idle
//   oTxStart     one-cycle start pulse per byte to uart_tx
//   oTxByte      byte to uart_tx, held until the next byte is issued
//   iTxBusy      uart_tx busy
//   iTxDone      uart_tx byte-complete pulse
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int NBYTES = 8,
  parameter int LEN_W  = len_width(NBYTES)
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [NREQ-1:0]          iReq,
  input  logic [NREQ*NBYTES*8-1:0] iData,
  input  logic [NREQ*LEN_W-1:0]    iLen,
  output logic [NREQ-1:0]          oGnt,
  output logic [NREQ-1:0]          oDone,
  output logic                     oBusy,
  output logic                     oTxStart,
  output logic [7:0]               oTxByte,
  input  logic                     iTxBusy,
  input  logic                     iTxDone
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int BUF_W = NBYTES * 8;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NBYTES);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [PTR_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_byte_q, tx_byte_d;

  logic [NREQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic [BUF_W-1:0]   req_data;
  logic [LEN_W-1:0]   req_len;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .iReq (iReq),
    .iPtr (ptr_q),
    .oGnt (arb_gnt),
    .oIdx (arb_idx)
  );

  assign req_data = iData[int'(arb_idx) * BUF_W +: BUF_W];
  assign req_len  = iLen[int'(arb_idx) * LEN_W +: LEN_W];

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      buf_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      buf_q      <= buf_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    buf_d      = buf_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;

    case (state_q)
      IDLE: begin
        if (|iReq) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          buf_d   = req_data;
          len_d   = (req_len > LEN_MAX) ? LEN_MAX : req_len;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (cnt_q < len_q) begin
          // Start is registered, so it reaches uart_tx one cycle after busy drops.
          if (!iTxBusy) begin
            tx_start_d = 1'b1;
            tx_byte_d  = buf_q[BUF_W-1 -: 8];
            buf_d      = buf_q << 8;
            cnt_d      = cnt_q + LEN_W'(1);
            state_d    = WAIT;
          end
        end else begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (iTxDone) begin
          state_d = SEND;
        end
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == PTR_W'(NREQ - 1)) ? '0 : idx_q + PTR_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decode the state register directly so an async reset clears them at once.
  assign oGnt     = gnt_q;
  assign oDone    = (state_q == DONE) ? gnt_q : '0;
  assign oBusy    = (state_q != IDLE);
  assign oTxStart = tx_start_q;
  assign oTxByte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NREQ   = 2;
  localparam int NBYTES = 8;
  localparam int LEN_W  = 4;

  logic                     iClk = 1'b0;
  logic                     iRst;
  logic [NREQ-1:0]          iReq;
  logic [NREQ*NBYTES*8-1:0] iData;
  logic [NREQ*LEN_W-1:0]    iLen;
  logic [NREQ-1:0]          oGnt;
  logic [NREQ-1:0]          oDone;
  logic                     oBusy;
  logic                     oTxStart;
  logic [7:0]               oTxByte;
  logic                     iTxBusy;
  logic                     iTxDone;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] tx_q[$];
  logic [1:0] txg_q[$];
  logic [1:0] done_q[$];
  int         overlap_err = 0;
  int         twohot_err  = 0;
  int         tx_rem      = 0;
  bit         force_busy  = 1'b0;
  int         ref_ptr     = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .NBYTES(NBYTES)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iData(iData), .iLen(iLen),
    .oGnt(oGnt), .oDone(oDone), .oBusy(oBusy), .oTxStart(oTxStart), .oTxByte(oTxByte),
    .iTxBusy(iTxBusy), .iTxDone(iTxDone)
  );

  always #5 iClk = ~iClk;

  // uart_tx stand-in plus event logger, acting 1 time unit after each rising edge.
  initial begin
    iTxBusy = 1'b0;
    iTxDone = 1'b0;
    forever begin
      @(posedge iClk);
      #1;
      if (iRst) begin
        tx_rem = 0; iTxBusy = 1'b0; iTxDone = 1'b0;
      end else begin
        if (oGnt == 2'b11) twohot_err++;
        if (oDone != 2'b00) done_q.push_back(oDone);
        iTxDone = 1'b0;
        if (oTxStart && tx_rem > 0) overlap_err++;
        if (force_busy) iTxBusy = 1'b1;
        else if (tx_rem > 0) begin
          tx_rem--;
          if (tx_rem == 0) begin iTxBusy = 1'b0; iTxDone = 1'b1; end
        end else iTxBusy = 1'b0;
        if (oTxStart) begin
          tx_q.push_back(oTxByte);
          txg_q.push_back(oGnt);
          iTxBusy = 1'b1;
          tx_rem  = $urandom_range(2, 6);
        end
      end
    end
  end

  // Reference: the k-th byte sent is the k-th most significant byte of the message.
  function automatic logic [7:0] ref_byte(input logic [63:0] d, input int k);
    logic [63:0] t;
    t = d >> (8 * (NBYTES - 1 - k));
    return t[7:0];
  endfunction

  function automatic int ref_len(input int l);
    return (l > NBYTES) ? NBYTES : l;
  endfunction

  function automatic int ref_grant(input logic [1:0] mask, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    tx_q.delete(); txg_q.delete(); done_q.delete();
  endtask

  task automatic apply_reset();
    iRst = 1'b1; iReq = '0; force_busy = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    ref_ptr = 0;
    @(negedge iClk);
    clear_logs();
  endtask

  task automatic wait_done(output bit ok, output logic [1:0] d);
    ok = 1'b0; d = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge iClk);
      if (oDone != 2'b00) begin ok = 1'b1; d = oDone; return; end
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iReq = '0; iData = '0; iLen = '0; force_busy = 1'b0;
    repeat (3) @(negedge iClk);
    vectors += 5;
    if (oGnt !== 2'b00)    begin miscompares++; $display("FAIL reset_gnt: got %b want 00", oGnt); end
    if (oDone !== 2'b00)   begin miscompares++; $display("FAIL reset_done: got %b want 00", oDone); end
    if (oBusy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    if (oTxStart !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b want 0", oTxStart); end
    if (oTxByte !== 8'h00) begin miscompares++; $display("FAIL reset_byte: got %h want 00", oTxByte); end
    iRst = 1'b0;
    @(negedge iClk);
    vectors++;
    if (oBusy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", oBusy); end
    ref_ptr = 0;
    clear_logs();
  endtask

  task automatic test_basic();
    bit ok; logic [1:0] d; logic [63:0] msg;
    logic [7:0] exp[3] = '{8'hAA, 8'hBB, 8'hCC};
    msg = {24'hAABBCC, 8'($urandom), 32'($urandom)};
    iData = {32'($urandom), 32'($urandom), msg};
    iLen  = {4'($urandom_range(0, 15)), 4'd3};
    iReq  = 2'b01;
    @(negedge iClk);
    vectors++;
    if (oGnt !== 2'b01) begin miscompares++; $display("FAIL basic_gnt_latency: got %b want 01", oGnt); end
    wait_done(ok, d);
    iReq = 2'b00;
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL basic_timeout: got no oDone want oDone"); end
    if (d !== 2'b01) begin miscompares++; $display("FAIL basic_done: got %b want 01", d); end
    @(negedge iClk);
    vectors += 5;
    if (oBusy !== 1'b0 || oDone !== 2'b00) begin miscompares++; $display("FAIL basic_after: got busy=%b done=%b want 0 00", oBusy, oDone); end
    if (tx_q.size() != 3) begin miscompares++; $display("FAIL basic_count: got %0d want 3", tx_q.size()); end
    else for (int i = 0; i < 3; i++)
      if (tx_q[i] !== exp[i] || txg_q[i] !== 2'b01) begin miscompares++; $display("FAIL basic_byte%0d: got %h/%b want %h/01", i, tx_q[i], txg_q[i], exp[i]); end
    if (done_q.size() != 1) begin miscompares++; $display("FAIL basic_done_width: got %0d want 1", done_q.size()); end
    if (overlap_err != 0) begin miscompares++; $display("FAIL basic_overlap: got %0d want 0", overlap_err); end
    ref_ptr = 1;
    clear_logs();
  endtask

  task automatic test_simultaneous();
    bit ok; logic [1:0] d; int g; int lens[2]; logic [63:0] m[2];
    logic [7:0] exp[$]; logic [1:0] expg[$];
    apply_reset();
    for (int k = 0; k < 2; k++) begin m[k] = {32'($urandom), 32'($urandom)}; lens[k] = $urandom_range(1, 4); end
    iData = {m[1], m[0]};
    iLen  = {4'(lens[1]), 4'(lens[0])};
    iReq  = 2'b11;
    for (int n = 0; n < 4; n++) begin
      g = ref_grant(2'b11, ref_ptr);
      for (int i = 0; i < lens[g]; i++) begin exp.push_back(ref_byte(m[g], i)); expg.push_back(2'(1 << g)); end
      wait_done(ok, d);
      if (n == 3) iReq = 2'b00;
      vectors++;
      if (!ok || d !== 2'(1 << g)) begin miscompares++; $display("FAIL rr_done%0d: got %b want %b", n, d, 2'(1 << g)); end
      ref_ptr = (g + 1) % NREQ;
    end
    @(negedge iClk);
    vectors += 3;
    if (twohot_err != 0) begin miscompares++; $display("FAIL rr_twohot: got %0d want 0", twohot_err); end
    if (tx_q.size() != exp.size()) begin miscompares++; $display("FAIL rr_count: got %0d want %0d", tx_q.size(), exp.size()); end
    else for (int i = 0; i < exp.size(); i++)
      if (tx_q[i] !== exp[i] || txg_q[i] !== expg[i]) begin miscompares++; $display("FAIL rr_byte%0d: got %h/%b want %h/%b", i, tx_q[i], txg_q[i], exp[i], expg[i]); end
    if (done_q.size() != 4) begin miscompares++; $display("FAIL rr_done_count: got %0d want 4", done_q.size()); end
    clear_logs();
  endtask

  task automatic test_zero_len();
    int gcnt = 0; bit seen = 0;
    iData = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    iLen  = {4'd0, 4'($urandom_range(1, 8))};
    iReq  = 2'b10;
    for (int c = 0; c < 20; c++) begin
      @(negedge iClk);
      if (oGnt == 2'b10) gcnt++;
      if (oDone == 2'b10) begin seen = 1; iReq = 2'b00; end
      if (seen && !oBusy) break;
    end
    vectors += 4;
    if (gcnt != 2) begin miscompares++; $display("FAIL zero_gnt_cycles: got %0d want 2", gcnt); end
    if (!seen) begin miscompares++; $display("FAIL zero_done: got none want 10"); end
    if (tx_q.size() != 0) begin miscompares++; $display("FAIL zero_starts: got %0d want 0", tx_q.size()); end
    if (done_q.size() != 1) begin miscompares++; $display("FAIL zero_done_count: got %0d want 1", done_q.size()); end
    ref_ptr = 0;
    clear_logs();
  endtask

  task automatic test_clamp();
    bit ok; logic [1:0] d; logic [63:0] msg = 64'h12345678EFCDAB90;
    iData = {32'($urandom), 32'($urandom), msg};
    iLen  = {4'($urandom_range(0, 15)), 4'd12};
    iReq  = 2'b01;
    wait_done(ok, d);
    iReq = 2'b00;
    @(negedge iClk);
    vectors += 2;
    if (!ok || d !== 2'b01) begin miscompares++; $display("FAIL clamp_done: got %b want 01", d); end
    if (tx_q.size() != 8) begin miscompares++; $display("FAIL clamp_count: got %0d want 8", tx_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      vectors++;
      if (tx_q[i] !== ref_byte(msg, i)) begin miscompares++; $display("FAIL clamp_byte%0d: got %h want %h", i, tx_q[i], ref_byte(msg, i)); end
    end
    ref_ptr = 1;
    clear_logs();
  endtask

  task automatic test_busy_stall();
    bit ok; logic [1:0] d; int bad = 0; int len; int c; logic [63:0] msg;
    msg = {32'($urandom), 32'($urandom)};
    len = $urandom_range(1, 4);
    force_busy = 1'b1;
    @(negedge iClk);
    iData = {32'($urandom), 32'($urandom), msg};
    iLen  = {4'd0, 4'(len)};
    iReq  = 2'b01;
    @(negedge iClk);
    vectors++;
    if (oGnt !== 2'b01) begin miscompares++; $display("FAIL stall_gnt: got %b want 01", oGnt); end
    for (int k = 0; k < 50; k++) begin
      @(negedge iClk);
      if (oTxStart || !oBusy || oGnt != 2'b01) bad++;
    end
    vectors += 2;
    if (bad != 0) begin miscompares++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    if (tx_q.size() != 0) begin miscompares++; $display("FAIL stall_starts: got %0d want 0", tx_q.size()); end
    force_busy = 1'b0;
    c = 0;
    while (iTxBusy && c < 10) begin @(negedge iClk); c++; end
    vectors += 2;
    if (oTxStart !== 1'b0) begin miscompares++; $display("FAIL stall_early: got %b want 0", oTxStart); end
    @(negedge iClk);
    if (oTxStart !== 1'b1 || oTxByte !== ref_byte(msg, 0)) begin miscompares++; $display("FAIL stall_first: got %b/%h want 1/%h", oTxStart, oTxByte, ref_byte(msg, 0)); end
    wait_done(ok, d);
    iReq = 2'b00;
    @(negedge iClk);
    vectors++;
    if (!ok || tx_q.size() != len) begin miscompares++; $display("FAIL stall_count: got %0d want %0d", tx_q.size(), len); end
    ref_ptr = 1;
    clear_logs();
  endtask

  task automatic test_reset_mid();
    bit ok; logic [1:0] d; int c = 0; logic [63:0] msg;
    msg = {32'($urandom), 32'($urandom)};
    iData = {32'($urandom), 32'($urandom), msg};
    iLen  = {4'd3, 4'd5};
    iReq  = 2'b01;
    while (!(tx_q.size() == 2 && !oTxStart) && c < 200) begin @(negedge iClk); c++; end
    vectors++;
    if (c >= 200) begin miscompares++; $display("FAIL rstmid_reach: got timeout want byte 2 in flight"); end
    #2 iRst = 1'b1; iReq = 2'b00;
    #1;
    vectors++;
    if (oGnt !== 0 || oDone !== 0 || oBusy !== 0 || oTxStart !== 0 || oTxByte !== 0) begin
      miscompares++;
      $display("FAIL rstmid_async: got gnt=%b done=%b busy=%b start=%b byte=%h want all 0", oGnt, oDone, oBusy, oTxStart, oTxByte);
    end
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    ref_ptr = 0;
    @(negedge iClk);
    vectors++;
    if (done_q.size() != 0) begin miscompares++; $display("FAIL rstmid_nodone: got %0d want 0", done_q.size()); end
    clear_logs();
    iLen = {4'd2, 4'd5};
    iReq = 2'b11;
    @(negedge iClk);
    vectors++;
    if (oGnt !== 2'b01) begin miscompares++; $display("FAIL rstmid_ptr: got %b want 01", oGnt); end
    wait_done(ok, d);
    iReq = 2'b00;
    @(negedge iClk);
    vectors += 2;
    if (!ok || d !== 2'b01) begin miscompares++; $display("FAIL rstmid_done: got %b want 01", d); end
    if (tx_q.size() != 5) begin miscompares++; $display("FAIL rstmid_count: got %0d want 5", tx_q.size()); end
    else for (int i = 0; i < 5; i++)
      if (tx_q[i] !== ref_byte(msg, i)) begin miscompares++; $display("FAIL rstmid_byte%0d: got %h want %h", i, tx_q[i], ref_byte(msg, i)); end
    ref_ptr = 1;
    clear_logs();
  endtask

  task automatic test_random();
    bit ok; logic [1:0] d; logic [1:0] mask; int g; int lens[2]; logic [63:0] m[2];
    for (int n = 0; n < 8; n++) begin
      mask = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin m[k] = {32'($urandom), 32'($urandom)}; lens[k] = $urandom_range(0, 15); end
      iData = {m[1], m[0]};
      iLen  = {4'(lens[1]), 4'(lens[0])};
      g = ref_grant(mask, ref_ptr);
      iReq = mask;
      wait_done(ok, d);
      iReq = 2'b00;
      @(negedge iClk);
      vectors += 2;
      if (!ok || d !== 2'(1 << g)) begin miscompares++; $display("FAIL rand%0d_done: got %b want %b", n, d, 2'(1 << g)); end
      if (tx_q.size() != ref_len(lens[g])) begin miscompares++; $display("FAIL rand%0d_count: got %0d want %0d", n, tx_q.size(), ref_len(lens[g])); end
      else for (int i = 0; i < tx_q.size(); i++)
        if (tx_q[i] !== ref_byte(m[g], i)) begin miscompares++; $display("FAIL rand%0d_byte%0d: got %h want %h", n, i, tx_q[i], ref_byte(m[g], i)); end
      ref_ptr = (g + 1) % NREQ;
      clear_logs();
    end
    vectors++;
    if (overlap_err != 0 || twohot_err != 0) begin miscompares++; $display("FAIL rand_protocol: got overlap=%0d twohot=%0d want 0 0", overlap_err, twohot_err); end
  endtask

  initial begin
    iRst = 1'b1; iReq = '0; iData = '0; iLen = '0;
    test_reset();
    test_basic();
    test_simultaneous();
    test_zero_len();
    test_clamp();
    test_busy_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
